// File: rtl/pad_io_pkg.sv
// Shared constants for the pad ring controller: bank width, register map, debounce enable.
// Build option: define PAD_IO_DEBOUNCE_EN to put a debounce filter behind each pad synchroniser.
package pad_io_pkg;

    localparam int W_DEFAULT = 14;

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_IO   = 3'd3;
    localparam logic [2:0] ADDR_EVT  = 3'd4;
    localparam logic [2:0] ADDR_MASK = 3'd5;
    localparam int         NUM_REGS  = 6;

`ifdef PAD_IO_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    function automatic logic addr_mapped(input logic [2:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

endpackage

// File: rtl/pad_io_sync_filt.sv
// One pad bank: SYNC_STAGES-deep synchroniser, followed by a per-bit debounce filter
// when PAD_IO_DEBOUNCE_EN is defined (otherwise the synchronised value passes straight through).
module pad_io_sync_filt #(
    parameter int W           = 14,
    parameter int SYNC_STAGES = 2
`ifdef PAD_IO_DEBOUNCE_EN
    ,
    parameter int DB_CYCLES   = 4
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pad,
    output logic [W-1:0] filt
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PAD_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q [W];
    logic [W-1:0]  filt_q;

    // A bit flips only after DB_CYCLES consecutive disagreeing samples; agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int b = 0; b < W; b++) cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                if (synced[b] != filt_q[b]) begin
                    if (cnt_q[b] == CNT_LAST) begin
                        filt_q[b] <= synced[b];
                        cnt_q[b]  <= '0;
                    end else begin
                        cnt_q[b] <= cnt_q[b] + 1'b1;
                    end
                end else begin
                    cnt_q[b] <= '0;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = synced;
`endif

endmodule

// File: rtl/pad_io_ctrl.sv
// Core-side pad ring controller: register port, bidir pad drive, filtered pad inputs, edge IRQ.
// Build option: PAD_IO_DEBOUNCE_EN adds the debounce filter to both pad banks.
module pad_io_ctrl
    import pad_io_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pad_in_i,
    input  logic [W-1:0] pad_io_i,
    output logic [W-1:0] pad_io_o,
    output logic [W-1:0] pad_oe,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [W-1:0] cfg_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         irq
);

    // Edge detection stays off until the filtered IO bank has had time to reflect the pads.
    localparam int FILT_LAT = DEBOUNCE_EN ? DB_CYCLES : 0;
    localparam int ARM      = SYNC_STAGES + FILT_LAT + 1;
    localparam int ARMW     = $clog2(ARM + 1);

    logic [W-1:0]    in_filt, io_filt, io_prev_q;
    logic [W-1:0]    out_q, oe_q, evt_q, mask_q;
    logic [W-1:0]    rise, evt_clr;
    logic [W-1:0]    rd_data;
    logic            rd_err;
    logic            accept, wr;
    logic [ARMW-1:0] arm_cnt_q;
    logic            armed;
    logic            rsp_valid_q, rsp_err_q, irq_q;
    logic [W-1:0]    rsp_rdata_q;

    pad_io_sync_filt #(
        .W(W),
        .SYNC_STAGES(SYNC_STAGES)
`ifdef PAD_IO_DEBOUNCE_EN
        ,
        .DB_CYCLES(DB_CYCLES)
`endif
    ) u_in_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .pad  (pad_in_i),
        .filt (in_filt)
    );

    pad_io_sync_filt #(
        .W(W),
        .SYNC_STAGES(SYNC_STAGES)
`ifdef PAD_IO_DEBOUNCE_EN
        ,
        .DB_CYCLES(DB_CYCLES)
`endif
    ) u_io_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .pad  (pad_io_i),
        .filt (io_filt)
    );

    // Handshake: a request transfers on a cycle where cfg_valid & cfg_ready, a response on a
    // cycle where rsp_valid & rsp_ready; valid never waits for ready and, once raised, holds
    // with its payload unchanged until the transfer. One response slot, refilled on the
    // same edge it drains, so a continuously ready consumer sees one response per cycle.
    assign cfg_ready = !rsp_valid_q || rsp_ready;
    assign accept    = cfg_valid && cfg_ready;
    assign wr        = accept && cfg_we;

    always_comb begin
        rd_data = '0;
        rd_err  = !addr_mapped(cfg_addr);
        case (cfg_addr)
            ADDR_OUT:  rd_data = out_q;
            ADDR_OE:   rd_data = oe_q;
            ADDR_IN:   rd_data = in_filt;
            ADDR_IO:   rd_data = io_filt;
            ADDR_EVT:  rd_data = evt_q;
            ADDR_MASK: rd_data = mask_q;
            default:   rd_data = '0;
        endcase
    end

    assign armed   = (arm_cnt_q == ARMW'(ARM));
    assign rise    = io_filt & ~io_prev_q & {W{armed}};
    assign evt_clr = (wr && cfg_addr == ADDR_EVT) ? cfg_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
            io_prev_q <= '0;
        end else begin
            if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
            io_prev_q <= io_filt;
        end
    end

    // A fresh edge on the same edge as its W1C leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            oe_q   <= '0;
            mask_q <= '0;
            evt_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr && cfg_addr == ADDR_OUT)  out_q  <= cfg_wdata;
            if (wr && cfg_addr == ADDR_OE)   oe_q   <= cfg_wdata;
            if (wr && cfg_addr == ADDR_MASK) mask_q <= cfg_wdata;
            evt_q <= (evt_q & ~evt_clr) | rise;
            irq_q <= |(evt_q & mask_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cfg_we ? '0 : rd_data;
            rsp_err_q   <= rd_err;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end
    end

    assign pad_io_o  = out_q;
    assign pad_oe    = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Directed bench for pad_io_ctrl; scenario tasks run in sequence from one initial block.
// Builds with or without PAD_IO_DEBOUNCE_EN (latencies and the glitch scenario follow the macro).
module tb_pad_io_ctrl;
    import pad_io_pkg::*;

    localparam int W    = 14;
    localparam int SYNC = 2;
`ifdef PAD_IO_DEBOUNCE_EN
    localparam int LAT  = SYNC + 4;
`else
    localparam int LAT  = SYNC;
`endif

    localparam logic [2:0]   S_ADDR [8] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5};
    localparam logic [W-1:0] S_EXP  [8] = '{14'h2A5C, 14'h3FFF, 14'h0001, 14'h1234,
                                            14'h0000, 14'h2A5C, 14'h3FFF, 14'h0001};

    logic         clk;
    logic         rst_n;
    logic [W-1:0] pad_in_i, pad_io_i, pad_io_o, pad_oe;
    logic         cfg_valid, cfg_ready, cfg_we;
    logic [2:0]   cfg_addr;
    logic [W-1:0] cfg_wdata;
    logic         rsp_valid, rsp_ready, rsp_err, irq;
    logic [W-1:0] rsp_rdata;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] rd;
    logic         er;
    logic [W-1:0] exp_q [$];

    pad_io_ctrl #(.W(W), .SYNC_STAGES(SYNC), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_in_i (pad_in_i),
        .pad_io_i (pad_io_i),
        .pad_io_o (pad_io_o),
        .pad_oe   (pad_oe),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .irq      (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request/response; assumes rsp_ready=1 so the response drains on the following edge.
    task automatic xfer(input logic we, input logic [2:0] addr, input logic [W-1:0] wdata,
                        output logic [W-1:0] rdata, output logic err);
        int n;
        cfg_valid = 1'b1;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!cfg_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_accept_timeout: cfg_ready=%b, required 1 within 50 cycles", cfg_ready);
        end
        tick(1);
        cfg_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick(1);
            n++;
        end
        if (!rsp_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_rsp_timeout: rsp_valid=%b, required 1 within 50 cycles", rsp_valid);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic seen;
        rst_n = 1'b0; rsp_ready = 1'b1; cfg_valid = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; pad_in_i = '0; pad_io_i = 14'h0001;
        #1;
        vectors++;
        if ({pad_io_o, pad_oe, rsp_valid, rsp_rdata, rsp_err, irq} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got io_o=%h oe=%h rv=%b rd=%h re=%b irq=%b, required all 0",
                     pad_io_o, pad_oe, rsp_valid, rsp_rdata, rsp_err, irq);
        end
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready);
        end
        tick(3);
        rst_n = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = ADDR_OUT;
        tick(1);
        cfg_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_rsp_pending: got rsp_valid=%b, required 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_err, irq, pad_io_o, pad_oe} !== '0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_reset: got rv=%b re=%b irq=%b cfg_ready=%b, required 0 0 0 1",
                     rsp_valid, rsp_err, irq, cfg_ready);
        end
        tick(1);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= rsp_valid;
            tick(1);
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_no_rsp: got rsp_valid seen=%b, required 0", seen);
        end
        // pad_io_i[0] was high through reset: no edge may be recorded while disarmed
        xfer(1'b0, ADDR_EVT, '0, rd, er);
        vectors++;
        if (rd !== 14'h0000) begin
            miscompares++;
            $display("FAIL arm_no_evt: got EVT=%h, required 0000", rd);
        end
        pad_io_i = '0;
        tick(LAT + 2);
    endtask

    task automatic test_out_oe();
        vectors++;
        if (pad_io_o !== 14'h0000) begin
            miscompares++;
            $display("FAIL out_before_write: got %h, required 0000", pad_io_o);
        end
        xfer(1'b1, ADDR_OUT, 14'h2A5C, rd, er);
        vectors++;
        if (pad_io_o !== 14'h2A5C) begin
            miscompares++;
            $display("FAIL out_pad: got %h, required 2A5C", pad_io_o);
        end
        vectors++;
        if (rd !== 14'h0000 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL write_rsp: got rdata=%h err=%b, required 0000 0", rd, er);
        end
        xfer(1'b1, ADDR_OE, 14'h3FFF, rd, er);
        vectors++;
        if (pad_oe !== 14'h3FFF) begin
            miscompares++;
            $display("FAIL oe_pad: got %h, required 3FFF", pad_oe);
        end
        xfer(1'b0, ADDR_OUT, '0, rd, er);
        vectors++;
        if (rd !== 14'h2A5C || er !== 1'b0) begin
            miscompares++;
            $display("FAIL out_readback: got %h err=%b, required 2A5C 0", rd, er);
        end
        xfer(1'b0, ADDR_OE, '0, rd, er);
        vectors++;
        if (rd !== 14'h3FFF) begin
            miscompares++;
            $display("FAIL oe_readback: got %h, required 3FFF", rd);
        end
    endtask

    task automatic test_in_sync();
        pad_in_i = 14'h1234;
        tick(LAT - 1);
        xfer(1'b0, ADDR_IN, '0, rd, er);
        vectors++;
        if (rd !== 14'h0000) begin
            miscompares++;
            $display("FAIL in_too_early: got %h, required 0000", rd);
        end
        xfer(1'b0, ADDR_IN, '0, rd, er);
        vectors++;
        if (rd !== 14'h1234) begin
            miscompares++;
            $display("FAIL in_latency: got %h, required 1234", rd);
        end
    endtask

    task automatic test_evt_irq();
        xfer(1'b1, ADDR_MASK, 14'h0001, rd, er);
        pad_io_i = 14'h0001;
        tick(LAT + 1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_registered: got %b, required 0", irq);
        end
        tick(1);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set: got %b, required 1", irq);
        end
        pad_io_i = '0;
        xfer(1'b0, ADDR_EVT, '0, rd, er);
        vectors++;
        if (rd !== 14'h0001) begin
            miscompares++;
            $display("FAIL evt_set: got %h, required 0001", rd);
        end
        tick(LAT + 2);
        xfer(1'b1, ADDR_EVT, 14'h0001, rd, er);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_hold_after_w1c: got %b, required 1", irq);
        end
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: got %b, required 0", irq);
        end
        xfer(1'b0, ADDR_EVT, '0, rd, er);
        vectors++;
        if (rd !== 14'h0000) begin
            miscompares++;
            $display("FAIL evt_w1c: got %h, required 0000", rd);
        end
        // new edge lands on the same edge as the W1C
        pad_io_i = 14'h0001;
        tick(LAT);
        xfer(1'b1, ADDR_EVT, 14'h0001, rd, er);
        xfer(1'b0, ADDR_EVT, '0, rd, er);
        vectors++;
        if (rd !== 14'h0001) begin
            miscompares++;
            $display("FAIL evt_set_wins: got %h, required 0001", rd);
        end
        pad_io_i = '0;
        tick(LAT + 2);
        xfer(1'b1, ADDR_EVT, 14'h0001, rd, er);
        // unmasked bit records an event but never raises irq
        pad_io_i = 14'h0002;
        tick(LAT + 3);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_masked: got %b, required 0", irq);
        end
        xfer(1'b0, ADDR_EVT, '0, rd, er);
        vectors++;
        if (rd !== 14'h0002) begin
            miscompares++;
            $display("FAIL evt_masked_bit: got %h, required 0002", rd);
        end
        pad_io_i = '0;
        tick(LAT + 2);
        xfer(1'b1, ADDR_EVT, 14'h3FFF, rd, er);
        tick(1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_v;
        rsp_ready = 1'b0;
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = ADDR_OUT;
        tick(1);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 14'h2A5C) begin
            miscompares++;
            $display("FAIL stall_first_rsp: got rv=%b rd=%h, required 1 2A5C", rsp_valid, rsp_rdata);
        end
        cfg_addr = ADDR_OE;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cfg_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cfg_ready: got %b, required 0", cfg_ready);
            end
            tick(1);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 14'h2A5C) begin
                miscompares++;
                $display("FAIL stall_rsp_hold: got rv=%b rd=%h, required 1 2A5C", rsp_valid, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_cfg_ready: got %b, required 1", cfg_ready);
        end
        tick(1);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 14'h3FFF) begin
            miscompares++;
            $display("FAIL second_rsp: got rv=%b rd=%h, required 1 3FFF", rsp_valid, rsp_rdata);
        end
        for (int k = 0; k < 8; k++) begin
            cfg_addr = S_ADDR[k];
            exp_q.push_back(S_EXP[k]);
            tick(1);
            exp_v = exp_q.pop_front();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_v) begin
                miscompares++;
                $display("FAIL stream_%0d: got rv=%b rd=%h, required 1 %h", k, rsp_valid, rsp_rdata, exp_v);
            end
        end
        cfg_valid = 1'b0;
        tick(1);
        vectors++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_drain: got rv=%b pending=%0d, required 0 0", rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_err_debounce();
        xfer(1'b0, 3'd6, '0, rd, er);
        vectors++;
        if (rd !== 14'h0000 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL unmapped_read: got rd=%h err=%b, required 0000 1", rd, er);
        end
        xfer(1'b1, 3'd7, 14'h3FFF, rd, er);
        vectors++;
        if (rd !== 14'h0000 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL unmapped_write: got rd=%h err=%b, required 0000 1", rd, er);
        end
        xfer(1'b1, ADDR_IN, 14'h3FFF, rd, er);
        vectors++;
        if (er !== 1'b0) begin
            miscompares++;
            $display("FAIL ro_write_err: got %b, required 0", er);
        end
        xfer(1'b0, ADDR_IN, '0, rd, er);
        vectors++;
        if (rd !== 14'h1234) begin
            miscompares++;
            $display("FAIL ro_write_ignored: got %h, required 1234", rd);
        end
`ifdef PAD_IO_DEBOUNCE_EN
        pad_in_i = '0;
        tick(LAT + 2);
        pad_in_i = 14'h0020;
        tick(3);
        pad_in_i = '0;
        tick(LAT + 2);
        xfer(1'b0, ADDR_IN, '0, rd, er);
        vectors++;
        if (rd !== 14'h0000) begin
            miscompares++;
            $display("FAIL glitch_rejected: got %h, required 0000", rd);
        end
        pad_in_i = 14'h0020;
        tick(LAT + 1);
        xfer(1'b0, ADDR_IN, '0, rd, er);
        vectors++;
        if (rd !== 14'h0020) begin
            miscompares++;
            $display("FAIL debounce_accept: got %h, required 0020", rd);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_out_oe();
        test_in_sync();
        test_evt_irq();
        test_back_to_back();
        test_err_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
